// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg: geometry and state encoding shared by the cache and its line fill unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cache_pkg;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 30;
  localparam int DEF_BLOCK_SIZE    = 3;
  localparam int DEF_MEM_LATENCY   = 2;

  localparam int S         = 2**DEF_BLOCK_SIZE;
  localparam int JUST_DATA = DEF_DATA_WIDTH*S;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lfu_state_t;
endpackage

`default_nettype wire

// File: rtl/rd_valid_pipe.sv
// ----------------------------------------------------------------------------
// rd_valid_pipe: delays read-issue strobes by the memory latency to mark capture cycles
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic capture
);
  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages <= '0;
        else        stages <= issue;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages <= '0;
        else        stages <= {stages[DEPTH-2:0], issue};
      end
    end
  endgenerate

  assign capture = stages[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/line_fill_unit.sv
// ----------------------------------------------------------------------------
// line_fill_unit: serves whole-block fills and writes against a word-wide memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module line_fill_unit
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE,
  parameter int MEM_LATENCY   = DEF_MEM_LATENCY
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  input  logic                                req_write,
  input  logic [ADDRESS_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] req_wdata,
  output logic                                req_ready,
  output logic                                resp_valid,
  output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] resp_data,
  output logic [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic                                mem_re,
  output logic                                mem_we,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [DATA_WIDTH-1:0]               mem_rdata
);
  localparam int NWORDS   = 2**BLOCK_SIZE;
  localparam int BLK_BITS = DATA_WIDTH*NWORDS;
  localparam int TAG_BITS = ADDRESS_WIDTH-BLOCK_SIZE;
  localparam logic [BLOCK_SIZE-1:0] LAST = '1;

  lfu_state_t            state;
  logic [TAG_BITS-1:0]   blk;
  logic [BLK_BITS-1:0]   wbuf;
  logic [BLK_BITS-1:0]   asm_q;
  logic [BLK_BITS-1:0]   asm_nxt;
  logic [BLOCK_SIZE-1:0] k;
  logic [BLOCK_SIZE-1:0] k_nxt;
  logic [BLOCK_SIZE-1:0] c;
  logic                  cap;
  logic                  unused_offset;

  // The word offset inside the block never matters: every operation covers the whole block.
  assign unused_offset = ^req_addr[BLOCK_SIZE-1:0];
  assign k_nxt         = k + 1'b1;

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[c*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end

  rd_valid_pipe #(.DEPTH(MEM_LATENCY)) u_rd_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (mem_re),
    .capture (cap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      blk        <= '0;
      wbuf       <= '0;
      asm_q      <= '0;
      k          <= '0;
      c          <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            blk       <= req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
            wbuf      <= req_wdata;
            k         <= '0;
            c         <= '0;
            req_ready <= 1'b0;
            mem_addr  <= {req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
            if (req_write) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata[DATA_WIDTH-1:0];
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (k == LAST) begin
            mem_we     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= wbuf;
          end else begin
            k         <= k_nxt;
            mem_addr  <= {blk, k_nxt};
            mem_wdata <= wbuf[k_nxt*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        READ: begin
          // Issue and capture run independently; capture may outlast issue when latency > S.
          if (mem_re) begin
            if (k == LAST) begin
              mem_re <= 1'b0;
            end else begin
              k        <= k_nxt;
              mem_addr <= {blk, k_nxt};
            end
          end
          if (cap) begin
            asm_q <= asm_nxt;
            c     <= c + 1'b1;
            if (c == LAST) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= asm_nxt;
            end
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_line_fill_unit.sv
// ----------------------------------------------------------------------------
// tb_line_fill_unit: directed checks of fills, writes, busy, latency, reset abort, top block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_line_fill_unit;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 req_valid  [3];
  logic                 req_write  [3];
  logic [29:0]          req_addr   [3];
  logic [JUST_DATA-1:0] req_wdata  [3];
  logic                 req_ready  [3];
  logic                 resp_valid [3];
  logic [JUST_DATA-1:0] resp_data  [3];
  logic [29:0]          mem_addr   [3];
  logic                 mem_re     [3];
  logic                 mem_we     [3];
  logic [31:0]          mem_wdata  [3];
  logic [31:0]          mem_rdata  [3];

  int checks   = 0;
  int failures = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 9);
  endfunction

  // Instance 0 uses the default latency; instances 1 and 2 sweep latency 1 and 9.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 9);

    line_fill_unit #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3), .MEM_LATENCY(LAT)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_ready  (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .resp_data  (resp_data[g]),
      .mem_addr   (mem_addr[g]),
      .mem_re     (mem_re[g]),
      .mem_we     (mem_we[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );

    // Backing memory: word[a] = 0xA000_0000 + a unless written (writes tracked for low addresses).
    logic        wr_ok  [64];
    logic [31:0] wr_dat [64];
    logic [31:0] rpipe  [LAT];

    initial for (int i = 0; i < 64; i++) wr_ok[i] = 1'b0;

    always @(posedge clk) begin
      if (mem_we[g] && mem_addr[g][29:6] == 24'd0) begin
        wr_ok[mem_addr[g][5:0]]  <= 1'b1;
        wr_dat[mem_addr[g][5:0]] <= mem_wdata[g];
      end
      if (mem_re[g])
        rpipe[0] <= (mem_addr[g][29:6] == 24'd0 && wr_ok[mem_addr[g][5:0]])
                    ? wr_dat[mem_addr[g][5:0]] : 32'hA000_0000 + 32'(mem_addr[g]);
      else
        rpipe[0] <= 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[g] = rpipe[LAT-1];
  end

  task automatic check(input string tag, input logic [JUST_DATA-1:0] got,
                       input logic [JUST_DATA-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [JUST_DATA-1:0] fill_blk(input logic [29:0] base);
    logic [JUST_DATA-1:0] r;
    for (int i = 0; i < S; i++) r[i*32 +: 32] = 32'hA000_0000 + 32'(base) + 32'(i);
    return r;
  endfunction

  // Presents one request at a negedge, checks every cycle through one cycle past the response.
  task automatic run_op(input int g, input bit wr, input logic [29:0] addr,
                        input logic [JUST_DATA-1:0] wd, input logic [JUST_DATA-1:0] exp_blk,
                        input bit nxt_valid, input logic [29:0] nxt_addr);
    int exp_cyc;
    logic [29:0] base;
    exp_cyc = wr ? S + 1 : S + lat_of(g) + 1;
    base    = {addr[29:3], 3'b000};
    req_valid[g] = 1'b1;
    req_write[g] = wr;
    req_addr[g]  = addr;
    req_wdata[g] = wd;
    check("ready_idle", req_ready[g], 1);
    @(posedge clk);
    for (int n = 1; n <= exp_cyc + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid[g] = nxt_valid;
        req_write[g] = 1'b0;
        req_addr[g]  = nxt_addr;
        req_wdata[g] = ~wd;
      end
      check("req_ready", req_ready[g], (n > exp_cyc));
      check("resp_valid", resp_valid[g], (n == exp_cyc));
      check(wr ? "mem_we" : "mem_re", wr ? mem_we[g] : mem_re[g], (n <= S));
      check(wr ? "mem_re_idle" : "mem_we_idle", wr ? mem_re[g] : mem_we[g], 0);
      if (n <= S) begin
        check("mem_addr", mem_addr[g], 30'(base + 30'(n - 1)));
        if (wr) check("mem_wdata", mem_wdata[g], wd[(n-1)*32 +: 32]);
      end
      if (n >= exp_cyc) check("resp_data", resp_data[g], exp_blk);
    end
  endtask

  logic [JUST_DATA-1:0] wblk;

  initial begin
    for (int g = 0; g < 3; g++) begin
      req_valid[g] = 1'b0;
      req_write[g] = 1'b0;
      req_addr[g]  = '0;
      req_wdata[g] = '0;
    end
    for (int i = 0; i < S; i++) wblk[i*32 +: 32] = 32'h5500 + 32'(i);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready[0], 1);
    check("rst_resp_valid", resp_valid[0], 0);
    check("rst_resp_data", resp_data[0], 0);
    check("rst_mem_re", mem_re[0], 0);
    check("rst_mem_we", mem_we[0], 0);
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_mem_wdata", mem_wdata[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 1'b0, 30'h13, '0, fill_blk(30'h10), 1'b0, 30'h0);
    run_op(0, 1'b1, 30'h2F, wblk, wblk, 1'b0, 30'h0);
    run_op(0, 1'b0, 30'h28, '0, wblk, 1'b0, 30'h0);
    // Busy: the second request is held throughout the first fill and taken in cycle 12.
    run_op(0, 1'b0, 30'h13, '0, fill_blk(30'h10), 1'b1, 30'h40);
    run_op(0, 1'b0, 30'h40, '0, fill_blk(30'h40), 1'b0, 30'h0);
    run_op(1, 1'b0, 30'h13, '0, fill_blk(30'h10), 1'b0, 30'h0);
    run_op(2, 1'b0, 30'h13, '0, fill_blk(30'h10), 1'b0, 30'h0);

    // Reset abort in cycle 5 of a fill, then an immediate fresh fill.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 30'h50;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
    end
    check("abort_pre_mem_re", mem_re[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", req_ready[0], 1);
    check("abort_resp_valid", resp_valid[0], 0);
    check("abort_resp_data", resp_data[0], 0);
    check("abort_mem_re", mem_re[0], 0);
    check("abort_mem_we", mem_we[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 30'h58, '0, fill_blk(30'h58), 1'b0, 30'h0);

    run_op(0, 1'b0, 30'h3FFF_FFFF, '0, fill_blk(30'h3FFF_FFF8), 1'b0, 30'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
- Memory-side responder to the direct-mapped cache.
- Serves whole-block requests: line fills on a miss, and whole-block writes.
- Accepts one block request, then performs DATA_WIDTH-wide beats against a word-wide backing memory with fixed pipelined read latency.
- Returns the assembled block on resp_data, pulsing resp_valid for one cycle.

Parameters:
- DATA_WIDTH, 32, width of one memory word.
- ADDRESS_WIDTH, 30, word address width; same as the cache.
- BLOCK_SIZE, 3, log2 of words per block (S = 8).
- MEM_LATENCY, 2, cycles from mem_re to valid mem_rdata; legal range >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  block request present; held by the requester until accepted.
- req_write  in  1  1 = write block, 0 = fill (read) block.
- req_addr  in  ADDRESS_WIDTH  any word address inside the target block; low BLOCK_SIZE bits ignored.
- req_wdata  in  DATA_WIDTH*2**BLOCK_SIZE  block to write; word i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle pulse when the block operation completes.
- resp_data  out  DATA_WIDTH*2**BLOCK_SIZE  fill result, or echo of the written block; held until the next response.
- mem_addr  out  ADDRESS_WIDTH  backing-memory word address.
- mem_re  out  1  read strobe, one word per cycle.
- mem_we  out  1  write strobe, one word per cycle.
- mem_wdata  out  DATA_WIDTH  write word.
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after the matching mem_re.

Behaviour:
- Reset (async assert, sync deassert edge): state = IDLE, all counters = 0, in-flight valid pipe cleared.
  - Outputs during reset: req_ready = 1, resp_valid = 0, resp_data = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Accept: a request is accepted when req_valid && req_ready at an edge.
  - Latch base = {req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], BLOCK_SIZE'b0}, req_write and req_wdata.
  - The requester may change its inputs after acceptance.
- States: IDLE, WRITE, READ, RESP.
  - IDLE -> WRITE if accepted with req_write = 1; IDLE -> READ if accepted with req_write = 0.
- WRITE: beat k = 0..S-1, one per cycle.
  - mem_we = 1, mem_addr = base + k, mem_wdata = word k of the latched data.
  - After beat S-1, go to RESP; resp_data = latched write data.
- READ issue: issue counter k = 0..S-1.
  - mem_re = 1, mem_addr = base + k, one per cycle; no gaps, no stalls.
  - Each issue pushes a 1 into the MEM_LATENCY-deep valid pipe.
- READ capture: when the pipe output is 1, mem_rdata is written into word slot c of the assembly register and c increments.
  - Capture is concurrent with issue when MEM_LATENCY < S.
  - When c reaches S (last capture edge), go to RESP.
- RESP: resp_valid = 1 for exactly one cycle; resp_data updated on entry; then -> IDLE.
- Latency, cycle 0 = acceptance cycle:
  - Write: beats in cycles 1..S; resp_valid in cycle S+1 (= 9 at defaults).
  - Read: issues in cycles 1..S; last capture in cycle S+MEM_LATENCY; resp_valid in cycle S+MEM_LATENCY+1 (= 11 at defaults).
- Busy: req_ready = 0 in WRITE, READ and RESP; req_valid is ignored, with no queueing.
  - Back-to-back minimum: the next acceptance is in the cycle after RESP.
- Address arithmetic: base + k never carries out of the block (low bits are zero).
  - The top block (all-ones upper bits) needs no wrap handling; ADDRESS_WIDTH-bit truncation applies.
- Outside active beats: mem_re = mem_we = 0; mem_addr and mem_wdata hold their last value.
- mem_re and mem_we are never both 1.
- Reset mid-operation:
  - Immediate return to IDLE.
  - Pending read returns are discarded (pipe cleared).
  - No resp_valid for the aborted request.
  - Partial writes already issued are not undone.

Decomposition:
- Shared package cache_pkg:
  - Derived constants S = 2**BLOCK_SIZE and JUST_DATA = DATA_WIDTH*S, so the cache and this block agree.
  - State enum lfu_state_t {IDLE, WRITE, READ, RESP}.
- One sub-module: rd_valid_pipe.
  - MEM_LATENCY-deep shift register of issue strobes; async active-low reset clears it.
  - Output marks capture cycles.

Test Plan:
- Fill at defaults: memory word[a] = 0xA000_0000 + a; req_addr = 0x13 (read).
  - Fill covers 0x10..0x17.
  - mem_re high in cycles 1..8, mem_addr 0x10..0x17.
  - resp_valid only in cycle 11.
  - resp_data word i = 0xA000_0010 + i.
- Write block: req_write = 1, req_addr = 0x2F, req_wdata word i = 0x5500 + i.
  - mem_we high in cycles 1..8 with addr 0x28..0x2F and data 0x5500..0x5507.
  - resp_valid only in cycle 9; resp_data = req_wdata.
  - A following fill of 0x28 returns the same words.
- Busy rejection: hold req_valid high continuously with a second request to 0x40 during the first fill.
  - req_ready = 0 throughout; second request accepted in cycle 12.
  - No overlap of mem_re streams.
- Latency sweep: MEM_LATENCY = 1 and 9 (> S).
  - resp_valid in cycles 10 and 18 respectively; data correct in both.
- Reset mid-fill: deassert rst_n in cycle 5 of a fill.
  - Outputs go to reset values immediately (req_ready = 1, resp_valid = 0, resp_data = 0, mem_re = mem_we = 0).
  - No resp_valid appears afterwards.
  - A new fill after release completes with correct data, unaffected by stale returns.
- Top block: req_addr = 0x3FFF_FFFF.
  - mem_addr 0x3FFF_FFF8..0x3FFF_FFFF, no wrap to 0.
